// File: rtl/stream_fifo_pkg.sv
// Shared types for the byte-stream FIFOs (input unpack and return path).
package stream_fifo_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic {
    STREAMING = 1'b0,
    DRAINING  = 1'b1
  } streamState_t;

endpackage

// File: rtl/byte_ring_buffer.sv
// Byte-addressed ring storage: multi-byte write at wrPtr, fixed-width read window at rdPtr.
module byte_ring_buffer
  import stream_fifo_pkg::*;
#(
  parameter int DEPTH    = 64,
  parameter int WR_BYTES = 8,
  parameter int RD_BYTES = 16,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  wrEn,
  input  logic [AW-1:0]         wrPtr,
  input  logic [WR_BYTES*8-1:0] wrData,
  input  logic [AW-1:0]         rdPtr,
  output logic [RD_BYTES*8-1:0] rdWindow
);

  // Storage is deliberately not reset; the owner masks unwritten bytes via its count.
  byte_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wrEn) begin
      for (int i = 0; i < WR_BYTES; i++) begin
        mem[wrPtr + AW'(i)] <= wrData[i*8 +: 8];
      end
    end
  end

  // Pointer addition wraps naturally because DEPTH is a power of two.
  always_comb begin
    for (int i = 0; i < RD_BYTES; i++) begin
      rdWindow[i*8 +: 8] = mem[rdPtr + AW'(i)];
    end
  end

endmodule

// File: rtl/input_unpack_fifo.sv
// Unpacks AXI-Stream words into a byte FIFO exposing a sliding window of the oldest bytes.
module input_unpack_fifo
  import stream_fifo_pkg::*;
#(
  parameter int NUM_BYTES_INPUT_WIDTH  = 8,
  parameter int NUM_BYTES_OUTPUT_WIDTH = 16,
  parameter int FIFO_DEPTH             = 64
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_BYTES_INPUT_WIDTH*8-1:0]  s_tdata,
  input  logic                                s_tvalid,
  output logic                                s_tready,
  input  logic                                s_tlast,
  output logic [NUM_BYTES_OUTPUT_WIDTH*8-1:0] dataOut,
  output logic [$clog2(FIFO_DEPTH):0]         dataOutBytesValid,
  input  logic                                dataOutShift,
  input  logic [$clog2(NUM_BYTES_OUTPUT_WIDTH):0] dataOutShiftCount,
  output logic                                endOfStream,
  output logic                                underflowError
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]  rdPtr, wrPtr;
  logic [CW-1:0]  count, countNext, shiftReq, shiftN;
  streamState_t   state, stateNext;
  logic           accept, underflowNext;
  logic [NUM_BYTES_OUTPUT_WIDTH*8-1:0] window;

  // A consume request larger than the held bytes is clamped to what is held.
  function automatic logic [CW-1:0] clampShift(input logic [CW-1:0] req,
                                               input logic [CW-1:0] held);
    return (req > held) ? held : req;
  endfunction

  byte_ring_buffer #(
    .DEPTH   (FIFO_DEPTH),
    .WR_BYTES(NUM_BYTES_INPUT_WIDTH),
    .RD_BYTES(NUM_BYTES_OUTPUT_WIDTH)
  ) ringBuf (
    .clk     (clk),
    .wrEn    (accept),
    .wrPtr   (wrPtr),
    .wrData  (s_tdata),
    .rdPtr   (rdPtr),
    .rdWindow(window)
  );

  always_comb begin
    s_tready = reset && (state == STREAMING) &&
               ((CW'(FIFO_DEPTH) - count) >= CW'(NUM_BYTES_INPUT_WIDTH));
    accept        = s_tvalid && s_tready;
    shiftReq      = CW'(dataOutShiftCount);
    shiftN        = dataOutShift ? clampShift(shiftReq, count) : '0;
    underflowNext = dataOutShift && ((shiftReq > count) || (shiftReq == '0));
    countNext     = count + (accept ? CW'(NUM_BYTES_INPUT_WIDTH) : '0) - shiftN;
  end

  // A tlast word fully consumed on its own accept edge never enters DRAINING.
  always_comb begin
    stateNext = state;
    case (state)
      STREAMING: if (accept && s_tlast && (countNext != '0)) stateNext = DRAINING;
      DRAINING:  if (countNext == '0) stateNext = STREAMING;
      default:   stateNext = STREAMING;
    endcase
  end

  always_comb begin
    dataOutBytesValid = count;
    endOfStream       = (state == DRAINING) && (count <= CW'(NUM_BYTES_OUTPUT_WIDTH));
    for (int i = 0; i < NUM_BYTES_OUTPUT_WIDTH; i++) begin
      dataOut[i*8 +: 8] = (CW'(i) < count) ? window[i*8 +: 8] : 8'h00;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdPtr          <= '0;
      wrPtr          <= '0;
      count          <= '0;
      state          <= STREAMING;
      underflowError <= 1'b0;
    end else begin
      if (accept) wrPtr <= wrPtr + AW'(NUM_BYTES_INPUT_WIDTH);
      rdPtr <= rdPtr + shiftN[AW-1:0];
      count <= countNext;
      state <= stateNext;
      if (underflowNext) underflowError <= 1'b1;
    end
  end

endmodule
